axi_lite_gpio_slave: RTL and testbench

AXI_LITE_GPIO_SLAVE -- requirements
Module: axi_lite_gpio_slave

---
 rtl/axi_lite_gpio_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_lite_gpio_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite GPIO slave: OUT/OE registers, synchronized pad inputs and
// rising-edge capture register.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*      AXI4-Lite write address/data/response channels
//   s_ar*/s_r*           AXI4-Lite read address/data channels
//   gpio_in              asynchronous pad inputs
//   gpio_out, gpio_oe    pad output data and output enables (1 = drive)
module axi_lite_gpio_slave #(
  parameter int unsigned GPIO_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe
);

  localparam int unsigned DATA_W = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] OFF_OUT  = ADDR_W'(4'h0);
  localparam logic [ADDR_W-1:0] OFF_OE   = ADDR_W'(4'h4);
  localparam logic [ADDR_W-1:0] OFF_IN   = ADDR_W'(4'h8);
  localparam logic [ADDR_W-1:0] OFF_EDGE = ADDR_W'(4'hC);

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  // Byte strobes expanded to a per-bit mask over the implemented GPIO bits.
  function automatic logic [GPIO_W-1:0] strb_mask(input logic [3:0] strb);
    return GPIO_W'({{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}});
  endfunction

  wstate_e           wstate_q, wstate_d;
  rstate_e           rstate_q, rstate_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q;
  logic [GPIO_W-1:0] wdata_q, wmask_q;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [GPIO_W-1:0] out_q, out_d, oe_q, oe_d, edge_q, edge_d, edge_clr;
  // sync3_q is the previous-cycle copy of the synchronized input for edge detect.
  logic [GPIO_W-1:0] sync1_q, sync2_q, sync3_q;

  logic              aw_hs, w_hs, ar_hs, wr_en, wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [GPIO_W-1:0] wr_data, wr_mask;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic              unused_wdata;

  assign unused_wdata = ^s_wdata;

  assign aw_hs   = s_awvalid & awready_q;
  assign w_hs    = s_wvalid & wready_q;
  assign ar_hs   = s_arvalid & arready_q;
  // Use the live channel in its handshake cycle, the captured copy otherwise.
  assign wr_addr = aw_hs ? s_awaddr : awaddr_q;
  assign wr_data = w_hs ? s_wdata[GPIO_W-1:0] : wdata_q;
  assign wr_mask = w_hs ? strb_mask(s_wstrb) : wmask_q;
  assign wr_ok   = (wr_addr == OFF_OUT) || (wr_addr == OFF_OE) || (wr_addr == OFF_EDGE);

  // Write FSM: collect AW and W in any order, commit, then hold B until taken.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        if (aw_held_d && w_held_d) begin
          wr_en     = 1'b1;
          wstate_d  = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          bvalid_d  = 1'b0;
          wstate_d  = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read decode of the live AR address; register values are pre-update.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_araddr)
      OFF_OUT:  rd_data = DATA_W'(out_q);
      OFF_OE:   rd_data = DATA_W'(oe_q);
      OFF_IN:   rd_data = DATA_W'(sync2_q);
      OFF_EDGE: rd_data = DATA_W'(edge_q);
      default:  rd_resp = RESP_SLVERR;
    endcase
  end

  // Read FSM: capture data on AR handshake, hold R until taken.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = rd_data;
          rresp_d  = rd_resp;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          rvalid_d  = 1'b0;
          rstate_d  = R_IDLE;
          arready_d = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Register file update; a same-cycle edge set wins over a W1C clear.
  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    edge_clr = '0;
    if (wr_en) begin
      case (wr_addr)
        OFF_OUT:  out_d    = (out_q & ~wr_mask) | (wr_data & wr_mask);
        OFF_OE:   oe_d     = (oe_q & ~wr_mask) | (wr_data & wr_mask);
        OFF_EDGE: edge_clr = wr_data & wr_mask;
        default:  ;
      endcase
    end
    edge_d = (edge_q & ~edge_clr) | (sync2_q & ~sync3_q);
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      edge_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata[GPIO_W-1:0];
        wmask_q <= strb_mask(s_wstrb);
      end
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      edge_q    <= edge_d;
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_oe   = oe_q;

endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// Directed bench for axi_lite_gpio_slave with a response scoreboard and a
// small register model.
module tb_axi_lite_gpio_slave;
  localparam int unsigned GPIO_W = 16;
  localparam int unsigned ADDR_W = 8;

  logic              aclk, aresetn;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]       s_wdata, s_rdata;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [GPIO_W-1:0] gpio_in, gpio_out, gpio_oe;

  int total = 0;
  int bad   = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [15:0] m_out, m_oe, m_edge;

  axi_lite_gpio_slave #(.GPIO_W(GPIO_W), .ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return {16'h0, m_out};
      8'h04:   return {16'h0, m_oe};
      8'h08:   return {16'h0, gpio_in};
      8'h0C:   return {16'h0, m_edge};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_rresp(input logic [7:0] a);
    return (a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    logic [15:0] m;
    m = {{8{s[1]}}, {8{s[0]}}};
    resp = 2'b00;
    case (a)
      8'h00:   m_out  = (m_out & ~m) | (d[15:0] & m);
      8'h04:   m_oe   = (m_oe & ~m) | (d[15:0] & m);
      8'h0C:   m_edge = m_edge & ~(d[15:0] & m);
      default: resp = 2'b10;
    endcase
  endtask

  task automatic wait_b();
    int n = 0;
    logic [1:0] e;
    s_bready = 1'b1;
    while (!s_bvalid && n < 50) begin @(negedge aclk); n++; end
    chk("bvalid", 32'(s_bvalid), 32'h1);
    e = exp_b.pop_front();
    chk("bresp", 32'(s_bresp), 32'(e));
    @(posedge aclk); #1 s_bready = 1'b0;
  endtask

  task automatic wait_r();
    int n = 0;
    logic [33:0] e;
    s_rready = 1'b1;
    while (!s_rvalid && n < 50) begin @(negedge aclk); n++; end
    chk("rvalid", 32'(s_rvalid), 32'h1);
    e = exp_r.pop_front();
    chk("rdata", s_rdata, e[31:0]);
    chk("rresp", 32'(s_rresp), 32'(e[33:32]));
    @(posedge aclk); #1 s_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic [1:0] r;
    model_write(a, d, s, r);
    exp_b.push_back(r);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while (!(s_awready && s_wready) && n < 50) begin @(negedge aclk); n++; end
    chk("aw_w_ready", {30'h0, s_awready, s_wready}, 32'h3);
    @(posedge aclk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_b();
  endtask

  task automatic axi_read_exp(input logic [7:0] a, input logic [33:0] e);
    int n = 0;
    exp_r.push_back(e);
    s_araddr = a; s_arvalid = 1'b1;
    while (!s_arready && n < 50) begin @(negedge aclk); n++; end
    chk("arready", 32'(s_arready), 32'h1);
    @(posedge aclk); #1 s_arvalid = 1'b0;
    wait_r();
  endtask

  task automatic axi_read(input logic [7:0] a);
    axi_read_exp(a, {model_rresp(a), model_read(a)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [33:0] pre;
    int n;
    aresetn = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0; gpio_in = '0;
    m_out = '0; m_oe = '0; m_edge = '0;

    // reset state
    #2 aresetn = 1'b0;
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_bvalid", 32'(s_bvalid), 32'h0);
    chk("rst_rvalid", 32'(s_rvalid), 32'h0);
    chk("rst_rdata", s_rdata, 32'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rel_ready", {29'h0, s_awready, s_wready, s_arready}, 32'h7);

    // OE then OUT
    axi_write(8'h04, 32'h0000FFFF, 4'hF);
    chk("gpio_oe_ffff", 32'(gpio_oe), 32'hFFFF);
    axi_write(8'h00, 32'h00000055, 4'hF);
    chk("gpio_out_55", 32'(gpio_out), 32'h0055);
    chk("awready_b2b", 32'(s_awready), 32'h1);

    // W ahead of AW, B held off for 5 cycles with a competing write pending
    model_write(8'h04, 32'h00000F0F, 4'hF, r);
    exp_b.push_back(r);
    s_wdata = 32'h00000F0F; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge aclk); #1 s_wvalid = 1'b0;
    @(negedge aclk);
    chk("wready_after_w", 32'(s_wready), 32'h0);
    @(negedge aclk);
    s_awaddr = 8'h04; s_awvalid = 1'b1; s_bready = 1'b0;
    chk("awready_wait", 32'(s_awready), 32'h1);
    @(posedge aclk); #1 s_awvalid = 1'b0;
    s_awaddr = 8'h00; s_wdata = 32'h0; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("hold_bvalid", 32'(s_bvalid), 32'h1);
      chk("hold_bresp", 32'(s_bresp), 32'h0);
      chk("hold_ready", {30'h0, s_awready, s_wready}, 32'h0);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("hold_oe", 32'(gpio_oe), 32'(m_oe));
    chk("hold_out", 32'(gpio_out), 32'(m_out));
    wait_b();

    // single byte strobe
    axi_write(8'h01 - 8'h01, 32'hAABBCCDD, 4'b0010);
    chk("gpio_out_cc55", 32'(gpio_out), 32'hCC55);

    // input sync and edge capture
    @(negedge aclk);
    gpio_in = 16'h00A0;
    repeat (4) @(negedge aclk);
    m_edge = m_edge | 16'h00A0;
    axi_read(8'h08);
    axi_read(8'h0C);
    chk("arready_b2b", 32'(s_arready), 32'h1);
    axi_write(8'h0C, 32'h00000020, 4'hF);
    axi_read(8'h0C);

    // edge set collides with W1C clear of the same bit
    @(negedge aclk);
    gpio_in = 16'h00A1;
    repeat (2) @(negedge aclk);
    axi_write(8'h0C, 32'h00000001, 4'hF);
    m_edge = m_edge | 16'h0001;
    axi_read(8'h0C);
    axi_read(8'h08);

    // unmapped and read-only writes, unmapped read, upper bits ignored
    axi_write(8'h10, 32'h0000FFFF, 4'hF);
    axi_write(8'h08, 32'h0000FFFF, 4'hF);
    chk("err_out", 32'(gpio_out), 32'(m_out));
    chk("err_oe", 32'(gpio_oe), 32'(m_oe));
    axi_read(8'h20);
    axi_read(8'h04);
    axi_write(8'h00, 32'hFFFF0055, 4'hF);
    axi_read(8'h00);

    // read accepted with a write to the same register sees the old value
    pre = {2'b00, model_read(8'h00)};
    fork
      axi_write(8'h00, 32'h00001234, 4'hF);
      axi_read_exp(8'h00, pre);
    join
    chk("gpio_out_1234", 32'(gpio_out), 32'h1234);
    axi_read(8'h00);

    // async reset while R waits
    s_araddr = 8'h00; s_arvalid = 1'b1; s_rready = 1'b0;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge aclk); n++; end
    @(posedge aclk); #1 s_arvalid = 1'b0;
    @(negedge aclk);
    chk("pend_rvalid", 32'(s_rvalid), 32'h1);
    chk("pend_rdata", s_rdata, 32'(m_out));
    #2 aresetn = 1'b0;
    #1;
    chk("async_rvalid", 32'(s_rvalid), 32'h0);
    chk("async_out", 32'(gpio_out), 32'h0);
    chk("async_oe", 32'(gpio_oe), 32'h0);
    chk("async_rdata", s_rdata, 32'h0);
    m_out = '0; m_oe = '0; m_edge = '0;
    exp_r.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rel2_ready", {29'h0, s_awready, s_wready, s_arready}, 32'h7);
    chk("rel2_rvalid", 32'(s_rvalid), 32'h0);
    @(negedge aclk);
    axi_read_exp(8'h0C, 34'h0);
    m_edge = 16'h00A1;
    axi_read(8'h0C);
    axi_read(8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
